// File: rtl/rca_nibble_serial_adder.sv
// Purpose: WIDTH-bit adder that reuses one 4-bit ripple-carry slice, one nibble per cycle.
// Latency: OUT_VALID rises WIDTH/4 rising edges after the accept edge.
// Backpressure: the result is held in DONE until OUT_READY, and IN_READY stays low until then.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   IN_VALID/IN_READY   operand handshake (A, B, CIN)
//   OUT_VALID/OUT_READY result handshake (SUM, COUT)
//   BUSY                high while nibbles are being added

// Combinational 4-bit ripple-carry slice.
module rca_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);
  always_comb begin
    logic [4:0] w_c;
    w_c    = '0;
    w_c[0] = CIN;
    SUM    = '0;
    for (int i = 0; i < 4; i++) begin
      SUM[i]   = A[i] ^ B[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end
    COUT = w_c[4];
  end
endmodule

module rca_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             BUSY
);

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("rca_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_vld;

  logic             w_accept;
  logic             w_last;
  logic [IW+1:0]    w_shamt;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;

  assign IN_READY  = (r_state == S_IDLE) && !RST;
  assign BUSY      = (r_state == S_ADD);
  assign OUT_VALID = r_out_vld;
  assign SUM       = r_sum;
  assign COUT      = r_cout;

  assign w_accept = IN_VALID && IN_READY;
  assign w_last   = (r_idx == IW'(NIB - 1));
  // Bit offset of the current nibble: index * 4.
  assign w_shamt  = {r_idx, 2'b00};
  assign w_a_nib  = 4'(r_a >> w_shamt);
  assign w_b_nib  = 4'(r_b >> w_shamt);

  rca_4bit u_slice (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .CIN  (r_carry),
    .SUM  (w_slice_sum),
    .COUT (w_slice_cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ADD;
      S_ADD:   if (w_last) w_next = S_DONE;
      S_DONE:  if (r_out_vld && OUT_READY) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a       <= '0;
      r_b       <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= CIN;
            r_idx   <= '0;
          end
        end
        S_ADD: begin
          // Replace only the nibble being processed; others keep earlier results.
          r_sum   <= (r_sum & ~(WIDTH'(4'hF) << w_shamt)) |
                     (WIDTH'(w_slice_sum) << w_shamt);
          r_carry <= w_slice_cout;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout    <= w_slice_cout;
            r_out_vld <= 1'b1;
          end
        end
        S_DONE: begin
          if (OUT_READY) r_out_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_nibble_serial_adder.sv
module tb_rca_nibble_serial_adder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // WIDTH=16 instance
  logic        in_vld16 = 1'b0;
  logic        in_rdy16;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        out_vld16;
  logic        out_rdy16 = 1'b1;
  logic [15:0] sum16;
  logic        cout16;
  logic        busy16;

  // WIDTH=4 instance
  logic        in_vld4 = 1'b0;
  logic        in_rdy4;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        out_vld4;
  logic        out_rdy4 = 1'b1;
  logic [3:0]  sum4;
  logic        cout4;
  logic        busy4;

  rca_nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_vld16), .IN_READY(in_rdy16),
    .A(a16), .B(b16), .CIN(cin16), .OUT_VALID(out_vld16), .OUT_READY(out_rdy16),
    .SUM(sum16), .COUT(cout16), .BUSY(busy16)
  );

  rca_nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .IN_VALID(in_vld4), .IN_READY(in_rdy4),
    .A(a4), .B(b4), .CIN(cin4), .OUT_VALID(out_vld4), .OUT_READY(out_rdy4),
    .SUM(sum4), .COUT(cout4), .BUSY(busy4)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for IN_READY of the 16-bit instance, then presents
  // operands for one accept edge and follows the result to OUT_VALID.
  task automatic send16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    int busy_n;
    int w;
    w = 0;
    while (!in_rdy16 && w < 50) begin
      step();
      w++;
    end
    check({tag, "_rdy_tmo"}, 32'(in_rdy16), 32'd1);
    in_vld16 = 1'b1;
    a16 = a;
    b16 = b;
    cin16 = cin;
    step();
    in_vld16 = 1'b0;
    a16 = 16'hDEAD;
    b16 = 16'hBEEF;
    cin16 = 1'b1;
    lat = 0;
    busy_n = 0;
    while (!out_vld16 && lat < 20) begin
      if (busy16) busy_n++;
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_busy"}, 32'(busy_n), 32'd4);
    check({tag, "_sum"}, 32'(sum16), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout16), 32'(exp_cout));
  endtask

  initial begin
    int prev_acc;
    int lat;
    int w;
    logic [4:0] exp5;

    // Reset
    repeat (3) step();
    check("rst_inrdy", 32'(in_rdy16), 32'd0);
    check("rst_ovld", 32'(out_vld16), 32'd0);
    check("rst_sum", 32'(sum16), 32'd0);
    check("rst_cout", 32'(cout16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    RST = 1'b0;
    #1;
    check("rst_rel_inrdy", 32'(in_rdy16), 32'd1);

    // Basic add, then return to IDLE with OUT_READY high
    send16("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    step();
    check("t1_ovld_clr", 32'(out_vld16), 32'd0);
    check("t1_inrdy", 32'(in_rdy16), 32'd1);

    // Full ripple across every nibble
    send16("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    step();
    send16("t3", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
    step();

    // Backpressure with an ignored operand pulse in DONE
    out_rdy16 = 1'b0;
    send16("bp", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_vld16 = 1'b1;
        a16 = 16'h1111;
        b16 = 16'h1111;
        cin16 = 1'b0;
      end else begin
        in_vld16 = 1'b0;
      end
      step();
      check("bp_hold_ovld", 32'(out_vld16), 32'd1);
      check("bp_hold_sum", 32'(sum16), 32'h1000);
      check("bp_hold_cout", 32'(cout16), 32'd0);
      check("bp_hold_inrdy", 32'(in_rdy16), 32'd0);
    end
    in_vld16 = 1'b0;
    out_rdy16 = 1'b1;
    step();
    check("bp_rel_ovld", 32'(out_vld16), 32'd0);
    check("bp_rel_inrdy", 32'(in_rdy16), 32'd1);

    // Reset in the middle of an addition
    in_vld16 = 1'b1;
    a16 = 16'h8000;
    b16 = 16'h8000;
    cin16 = 1'b0;
    step();
    in_vld16 = 1'b0;
    step();
    check("mid_busy", 32'(busy16), 32'd1);
    RST = 1'b1;
    step();
    check("mid_sum", 32'(sum16), 32'd0);
    check("mid_cout", 32'(cout16), 32'd0);
    check("mid_ovld", 32'(out_vld16), 32'd0);
    check("mid_busy0", 32'(busy16), 32'd0);
    check("mid_inrdy_rst", 32'(in_rdy16), 32'd0);
    RST = 1'b0;
    #1;
    check("mid_inrdy_rel", 32'(in_rdy16), 32'd1);
    send16("post", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    step();

    // WIDTH=4 exhaustive, OUT_READY held high
    prev_acc = 0;
    for (int i = 0; i < 512; i++) begin
      w = 0;
      while (!in_rdy4 && w < 20) begin
        step();
        w++;
      end
      if (w >= 20) check("w4_rdy_tmo", 32'(in_rdy4), 32'd1);
      in_vld4 = 1'b1;
      a4 = 4'(i >> 5);
      b4 = 4'(i >> 1);
      cin4 = i[0];
      exp5 = 5'(i >> 5) + 5'((i >> 1) & 15) + 5'(i & 1);
      step();
      if (i > 0) check("w4_period", 32'(cyc - prev_acc), 32'd3);
      prev_acc = cyc;
      in_vld4 = 1'b0;
      lat = 0;
      while (!out_vld4 && lat < 10) begin
        step();
        lat++;
      end
      check("w4_lat", 32'(lat), 32'd1);
      check("w4_res", 32'({cout4, sum4}), 32'(exp5));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
